alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 568 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq
// ----------------------------------------------------------------------------
// Issue/retire sequencer for the 8-bit datapath alu. It takes one 12-bit
// PIC16C5x-style ALU instruction at a time over a valid/ready handshake. For
// file-register instructions it first fetches the operand from the register
// file. It then presents the operands to the combinational alu for exactly one
// cycle. Finally it retires the result into W or writes it back to the file,
// and updates the STATUS C and Z flags.
//
// Optional feature (compile-time macro):
//   ALU_SEQ_ILLEGAL_TRAP_EN - an illegal instruction also raises a sticky
//                             'trap' that blocks new instructions until
//                             trap_clr is seen. Without it, illegal
//                             instructions only pulse 'err'.
//
// Ports:
//   clk, reset_n           rising-edge clock, asynchronous active-low reset
//   ins_valid/ins_ready    instruction handshake, ins = 12-bit word
//   fr_req/fr_addr         file read request, held until fr_ack;
//   fr_ack/fr_data         read data is valid while fr_ack is high
//   fw_req/fw_addr/fw_data file write request, held until fw_ack
//   alu_op/alu_a/alu_b     operands driven to the external alu
//   alu_cin                alu carry in (always the current STATUS C)
//   alu_y/alu_cout/alu_zout results returned by the alu
//   w_out, c_out, z_out    W register and STATUS C / Z
//   err                    one-cycle pulse after an illegal instruction
//   trap, trap_clr         sticky illegal flag and its clear
// ============================================================================
module alu_seq #(
    parameter int FA_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ins_valid,
    output logic            ins_ready,
    input  logic [11:0]     ins,
    output logic            fr_req,
    output logic [FA_W-1:0] fr_addr,
    input  logic            fr_ack,
    input  logic [7:0]      fr_data,
    output logic            fw_req,
    output logic [FA_W-1:0] fw_addr,
    output logic [7:0]      fw_data,
    input  logic            fw_ack,
    output logic [3:0]      alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic            alu_cin,
    input  logic [7:0]      alu_y,
    input  logic            alu_cout,
    input  logic            alu_zout,
    output logic [7:0]      w_out,
    output logic            c_out,
    output logic            z_out,
    output logic            err,
    output logic            trap,
    input  logic            trap_clr
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_COM  = 4'b0100;
    localparam logic [3:0] OP_ROR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_SWAP = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [3:0]        dec_op;
    logic              dec_file;
    logic              dec_lit;
    logic              is_illegal;
    logic              accept;

    logic [FA_W-1:0]   f_r;
    logic              d_r;
    logic              lit_r;
    logic              c_upd;
    logic              z_upd;

    // Instruction decode. File ops live in the 00xxxx space and literal ops
    // in the 11xx space, so the two lookups can never both hit.
    always_comb begin
        dec_op   = OP_ADD;
        dec_file = 1'b0;
        dec_lit  = 1'b0;
        case (ins[11:6])
            6'b000111: begin dec_op = OP_ADD;  dec_file = 1'b1; end
            6'b000010: begin dec_op = OP_SUB;  dec_file = 1'b1; end
            6'b000101: begin dec_op = OP_AND;  dec_file = 1'b1; end
            6'b000100: begin dec_op = OP_OR;   dec_file = 1'b1; end
            6'b000110: begin dec_op = OP_XOR;  dec_file = 1'b1; end
            6'b001001: begin dec_op = OP_COM;  dec_file = 1'b1; end
            6'b001100: begin dec_op = OP_ROR;  dec_file = 1'b1; end
            6'b001101: begin dec_op = OP_ROL;  dec_file = 1'b1; end
            6'b001110: begin dec_op = OP_SWAP; dec_file = 1'b1; end
            default: ;
        endcase
        case (ins[11:8])
            4'b1101: begin dec_op = OP_OR;  dec_lit = 1'b1; end
            4'b1110: begin dec_op = OP_AND; dec_lit = 1'b1; end
            4'b1111: begin dec_op = OP_XOR; dec_lit = 1'b1; end
            default: ;
        endcase
    end

    assign is_illegal = ~dec_file & ~dec_lit;
    assign accept     = ins_valid & ins_ready;

    // Only the carry-producing ops touch C; rotates and swap leave Z alone.
    assign c_upd = (alu_op == OP_ADD) || (alu_op == OP_SUB) ||
                   (alu_op == OP_ROR) || (alu_op == OP_ROL);
    assign z_upd = (alu_op != OP_ROR) && (alu_op != OP_ROL) &&
                   (alu_op != OP_SWAP);

    // State register. An async reset drops any pending file request at once,
    // because the requests are decoded straight from the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and request/ready outputs. Illegal instructions are
    // consumed in IDLE without leaving it.
    always_comb begin
        state_nx  = state;
        fr_req    = 1'b0;
        fw_req    = 1'b0;
        ins_ready = 1'b0;
        case (state)
            IDLE: begin
                ins_ready = ~trap;
                if (accept) begin
                    if (dec_file) begin
                        state_nx = READ;
                    end else if (dec_lit) begin
                        state_nx = EXEC;
                    end
                end
            end
            READ: begin
                fr_req = 1'b1;
                if (fr_ack) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = (d_r && !lit_r) ? WB : IDLE;
            end
            WB: begin
                fw_req = 1'b1;
                if (fw_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fr_addr = f_r;
    assign alu_cin = c_out;

    // Datapath registers. Operands are captured once, so the alu inputs stay
    // stable through EXEC. W is copied into the operand register at issue.
    // That is safe because W can only change at the end of EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_op  <= OP_ADD;
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            f_r     <= '0;
            d_r     <= 1'b0;
            lit_r   <= 1'b0;
            w_out   <= 8'h00;
            c_out   <= 1'b0;
            z_out   <= 1'b0;
            fw_addr <= '0;
            fw_data <= 8'h00;
            err     <= 1'b0;
        end else begin
            err <= accept & is_illegal;
            case (state)
                IDLE: begin
                    if (accept && !is_illegal) begin
                        alu_op <= dec_op;
                        f_r    <= ins[FA_W-1:0];
                        d_r    <= ins[5];
                        lit_r  <= dec_lit;
                        if (dec_lit) begin
                            alu_a <= w_out;
                            alu_b <= ins[7:0];
                        end else begin
                            alu_b <= w_out;
                        end
                    end
                end
                READ: begin
                    if (fr_ack) begin
                        alu_a <= fr_data;
                    end
                end
                EXEC: begin
                    if (c_upd) begin
                        c_out <= alu_cout;
                    end
                    if (z_upd) begin
                        z_out <= alu_zout;
                    end
                    if (d_r && !lit_r) begin
                        fw_data <= alu_y;
                        fw_addr <= f_r;
                    end else begin
                        w_out <= alu_y;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    // Sticky trap. New instructions are blocked while it is set, so a clear
    // and a fresh illegal acceptance can never land in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trap <= 1'b0;
        end else if (accept && is_illegal) begin
            trap <= 1'b1;
        end else if (trap_clr) begin
            trap <= 1'b0;
        end
    end
`else
    logic unused_trap_clr;

    assign trap            = 1'b0;
    assign unused_trap_clr = trap_clr;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq
// ----------------------------------------------------------------------------
// Bench for alu_seq. It contains a behavioural alu, a file-register memory
// with programmable read/write ack delays, and an instruction-level reference
// model. Expected W/C/Z, write-back and completion latency are pushed to a
// scoreboard queue when an instruction is issued. They are popped and
// compared once the sequencer is ready again.
// ============================================================================
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ins_valid;
    logic        ins_ready;
    logic [11:0] ins;
    logic        fr_req;
    logic [4:0]  fr_addr;
    logic        fr_ack;
    logic [7:0]  fr_data;
    logic        fw_req;
    logic [4:0]  fw_addr;
    logic [7:0]  fw_data;
    logic        fw_ack;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_y;
    logic        alu_cout;
    logic        alu_zout;
    logic [7:0]  w_out;
    logic        c_out;
    logic        z_out;
    logic        err;
    logic        trap;
    logic        trap_clr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] w;
        logic       c;
        logic       z;
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mem [0:31];
    logic [7:0] ref_w;
    logic       ref_c;
    logic       ref_z;
    int         fr_delay = 0;
    int         fw_delay = 0;
    int         rd_cycles = 0;
    int         wr_count = 0;
    logic [4:0] cap_addr = 5'd0;
    logic [7:0] cap_data = 8'h00;
    bit         stable_ok = 1'b1;

    always #5 clk = ~clk;

    alu_seq #(.FA_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .fr_req(fr_req), .fr_addr(fr_addr), .fr_ack(fr_ack), .fr_data(fr_data),
        .fw_req(fw_req), .fw_addr(fw_addr), .fw_data(fw_data), .fw_ack(fw_ack),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_zout(alu_zout),
        .w_out(w_out), .c_out(c_out), .z_out(z_out),
        .err(err), .trap(trap), .trap_clr(trap_clr)
    );

    // Behavioural alu.
    always_comb begin
        alu_y    = 8'h00;
        alu_cout = 1'b0;
        case (alu_op)
            4'b0000: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b1000: begin alu_y = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
            4'b0001: alu_y = alu_a & alu_b;
            4'b0010: alu_y = alu_a | alu_b;
            4'b0011: alu_y = alu_a ^ alu_b;
            4'b0100: alu_y = ~alu_a;
            4'b0101: begin alu_y = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
            4'b0110: begin alu_y = {alu_a[6:0], alu_cin}; alu_cout = alu_a[7]; end
            4'b0111: alu_y = {alu_a[3:0], alu_a[7:4]};
            default: ;
        endcase
        alu_zout = (alu_y == 8'h00);
    end

    assign fr_data = mem[fr_addr];

    // File read responder: ack after fr_delay waiting cycles.
    initial begin : rd_resp
        int cnt;
        cnt    = 0;
        fr_ack = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (fr_req) begin
                if (cnt == 0) rd_cycles = 0;
                rd_cycles++;
                fr_ack = (cnt >= fr_delay);
                cnt++;
            end else begin
                cnt    = 0;
                fr_ack = 1'b0;
            end
        end
    end

    // File write responder: ack after fw_delay waiting cycles, track stability.
    initial begin : wr_resp
        int cnt;
        cnt    = 0;
        fw_ack = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (fw_req) begin
                if (cnt == 0) begin
                    cap_addr  = fw_addr;
                    cap_data  = fw_data;
                    stable_ok = 1'b1;
                end else if (fw_addr !== cap_addr || fw_data !== cap_data) begin
                    stable_ok = 1'b0;
                end
                if (cnt == fw_delay) begin
                    fw_ack = 1'b1;
                    mem[cap_addr] = cap_data;
                    wr_count++;
                end else begin
                    fw_ack = 1'b0;
                end
                cnt++;
            end else begin
                cnt    = 0;
                fw_ack = 1'b0;
            end
        end
    end

    // Reference model: computes the architectural effect of one instruction
    // and pushes it to the scoreboard.
    task automatic predict_push(input logic [11:0] i);
        exp_t       e;
        logic [7:0] fv;
        logic [7:0] y;
        logic [8:0] s;
        logic       nc;
        logic       upc;
        logic       upz;
        bit         lit;
        bit         legal;
        fv = mem[i[4:0]];
        y = 8'h00; s = 9'h000; nc = ref_c; upc = 1'b0; upz = 1'b1;
        lit = 1'b0; legal = 1'b1;
        case (i[11:8])
            4'hD: begin y = ref_w | i[7:0]; lit = 1'b1; end
            4'hE: begin y = ref_w & i[7:0]; lit = 1'b1; end
            4'hF: begin y = ref_w ^ i[7:0]; lit = 1'b1; end
            default: begin
                case (i[11:6])
                    6'b000111: begin s = fv + ref_w; y = s[7:0]; nc = s[8]; upc = 1'b1; end
                    6'b000010: begin y = fv - ref_w; nc = (fv >= ref_w); upc = 1'b1; end
                    6'b000101: y = fv & ref_w;
                    6'b000100: y = fv | ref_w;
                    6'b000110: y = fv ^ ref_w;
                    6'b001001: y = ~fv;
                    6'b001100: begin y = {ref_c, fv[7:1]}; nc = fv[0]; upc = 1'b1; upz = 1'b0; end
                    6'b001101: begin y = {fv[6:0], ref_c}; nc = fv[7]; upc = 1'b1; upz = 1'b0; end
                    6'b001110: begin y = {fv[3:0], fv[7:4]}; upz = 1'b0; end
                    default:   legal = 1'b0;
                endcase
            end
        endcase
        e.wr = 1'b0; e.addr = 5'd0; e.data = 8'h00; e.w = ref_w;
        e.c = ref_c; e.z = ref_z; e.lat = 1;
        if (legal) begin
            e.c = upc ? nc : ref_c;
            e.z = upz ? (y == 8'h00) : ref_z;
            if (lit) begin
                e.w = y; e.lat = 2;
            end else if (!i[5]) begin
                e.w = y; e.lat = 3 + fr_delay;
            end else begin
                e.wr = 1'b1; e.addr = i[4:0]; e.data = y;
                e.lat = 4 + fr_delay + fw_delay;
            end
        end
        ref_w = e.w; ref_c = e.c; ref_z = e.z;
        sbq.push_back(e);
    endtask

    // Drive one instruction through the handshake; returns at edge+1 after it.
    task automatic send(input logic [11:0] i);
        int n;
        n = 0;
        while (!ins_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!ins_ready) begin
            errors++;
            $display("[TB] FAIL issue_timeout ins_ready actual=%b required=1", ins_ready);
        end
        ins = i;
        ins_valid = 1'b1;
        @(posedge clk); #1;
        ins_valid = 1'b0;
    endtask

    // Counts edges from the handshake edge until ins_ready returns (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!ins_ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic bench_reset();
        reset_n = 1'b0;
        ref_w = 8'h00; ref_c = 1'b0; ref_z = 1'b0;
        sbq.delete();
        fr_delay = 0; fw_delay = 0;
    endtask

    task automatic test_reset();
        ins_valid = 1'b0; ins = 12'h000; trap_clr = 1'b0;
        bench_reset();
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if ({w_out, c_out, z_out, err, trap} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_regs w/c/z/err/trap actual=%h/%b/%b/%b/%b required=00/0/0/0/0",
                     w_out, c_out, z_out, err, trap);
        end
        checks++;
        if ({fr_req, fw_req, fr_addr, fw_addr, fw_data} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_file fr_req=%b fw_req=%b fr_addr=%h fw_addr=%h fw_data=%h required all 0",
                     fr_req, fw_req, fr_addr, fw_addr, fw_data);
        end
        checks++;
        if ({alu_op, alu_a, alu_b, alu_cin} !== 21'h0) begin
            errors++;
            $display("[TB] FAIL reset_alu op=%h a=%h b=%h cin=%b required all 0", alu_op, alu_a, alu_b, alu_cin);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ins_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready ins_ready actual=%b required=1", ins_ready);
        end
    endtask

    task automatic test_literal();
        logic [11:0] prog [3];
        exp_t e;
        int lat;
        int wc0;
        prog = '{12'hEFF, 12'hD3C, 12'hF3C};
        for (int k = 0; k < 3; k++) begin
            wc0 = wr_count;
            predict_push(prog[k]);
            send(prog[k]);
            wait_done(lat);
            e = sbq.pop_front();
            checks++;
            if ({w_out, c_out, z_out} !== {e.w, e.c, e.z}) begin
                errors++;
                $display("[TB] FAIL literal_%0d w/c/z actual=%h/%b/%b required=%h/%b/%b",
                         k, w_out, c_out, z_out, e.w, e.c, e.z);
            end
            checks++;
            if (lat != e.lat || wr_count != wc0) begin
                errors++;
                $display("[TB] FAIL literal_%0d_lat latency actual=%0d required=%0d writes=%0d required=0",
                         k, lat, e.lat, wr_count - wc0);
            end
        end
    endtask

    task automatic test_subwf();
        logic [11:0] prog [2];
        exp_t e;
        int lat;
        int wc0;
        prog = '{12'hD05, 12'h0A3};
        mem[3] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            fr_delay = (k == 1) ? 2 : 0;
            fw_delay = 0;
            wc0 = wr_count;
            predict_push(prog[k]);
            send(prog[k]);
            wait_done(lat);
            e = sbq.pop_front();
            checks++;
            if ({w_out, c_out, z_out} !== {e.w, e.c, e.z}) begin
                errors++;
                $display("[TB] FAIL subwf_%0d w/c/z actual=%h/%b/%b required=%h/%b/%b",
                         k, w_out, c_out, z_out, e.w, e.c, e.z);
            end
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("[TB] FAIL subwf_%0d_lat latency actual=%0d required=%0d", k, lat, e.lat);
            end
            checks++;
            if (e.wr ? (wr_count != wc0 + 1 || cap_addr !== e.addr || cap_data !== e.data || !stable_ok)
                     : (wr_count != wc0)) begin
                errors++;
                $display("[TB] FAIL subwf_%0d_wr writes=%0d addr=%h data=%h stable=%b required wr=%b addr=%h data=%h",
                         k, wr_count - wc0, cap_addr, cap_data, stable_ok, e.wr, e.addr, e.data);
            end
        end
        checks++;
        if (rd_cycles != 3 || cap_data !== 8'hFE) begin
            errors++;
            $display("[TB] FAIL subwf_plan fr_req cycles=%0d fw_data=%h required 3 and FE", rd_cycles, cap_data);
        end
    endtask

    task automatic test_add_rrf();
        logic [11:0] prog [4];
        exp_t e;
        int lat;
        int wc0;
        prog = '{12'hE00, 12'hD80, 12'h1C4, 12'h305};
        mem[4] = 8'h80;
        mem[5] = 8'h01;
        fr_delay = 0; fw_delay = 0;
        for (int k = 0; k < 4; k++) begin
            wc0 = wr_count;
            predict_push(prog[k]);
            send(prog[k]);
            wait_done(lat);
            e = sbq.pop_front();
            checks++;
            if ({w_out, c_out, z_out} !== {e.w, e.c, e.z}) begin
                errors++;
                $display("[TB] FAIL add_rrf_%0d w/c/z actual=%h/%b/%b required=%h/%b/%b",
                         k, w_out, c_out, z_out, e.w, e.c, e.z);
            end
            checks++;
            if (lat != e.lat || wr_count != wc0) begin
                errors++;
                $display("[TB] FAIL add_rrf_%0d_lat latency actual=%0d required=%0d writes=%0d required=0",
                         k, lat, e.lat, wr_count - wc0);
            end
        end
        checks++;
        if ({w_out, c_out, z_out} !== {8'h80, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rrf_plan w/c/z actual=%h/%b/%b required=80/1/1", w_out, c_out, z_out);
        end
    endtask

    task automatic test_swapf();
        logic [11:0] prog [2];
        exp_t e;
        int lat;
        int wc0;
        prog = '{12'h3A6, 12'h246};
        mem[6] = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            fr_delay = 0;
            fw_delay = (k == 0) ? 3 : 0;
            wc0 = wr_count;
            predict_push(prog[k]);
            send(prog[k]);
            wait_done(lat);
            e = sbq.pop_front();
            checks++;
            if ({w_out, c_out, z_out} !== {e.w, e.c, e.z}) begin
                errors++;
                $display("[TB] FAIL swapf_%0d w/c/z actual=%h/%b/%b required=%h/%b/%b",
                         k, w_out, c_out, z_out, e.w, e.c, e.z);
            end
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("[TB] FAIL swapf_%0d_lat latency actual=%0d required=%0d", k, lat, e.lat);
            end
            checks++;
            if (e.wr ? (wr_count != wc0 + 1 || cap_addr !== e.addr || cap_data !== e.data || !stable_ok)
                     : (wr_count != wc0)) begin
                errors++;
                $display("[TB] FAIL swapf_%0d_wr writes=%0d addr=%h data=%h stable=%b required wr=%b addr=%h data=%h",
                         k, wr_count - wc0, cap_addr, cap_data, stable_ok, e.wr, e.addr, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fcodes [9];
        logic [3:0] lcodes [3];
        logic [11:0] i;
        exp_t e;
        int lat;
        int wc0;
        int sel;
        fcodes = '{6'b000111, 6'b000010, 6'b000101, 6'b000100, 6'b000110,
                   6'b001001, 6'b001100, 6'b001101, 6'b001110};
        lcodes = '{4'hD, 4'hE, 4'hF};
        for (int a = 8; a < 16; a++) mem[a] = 8'($urandom);
        for (int k = 0; k < 12; k++) begin
            sel = int'($urandom_range(11));
            if (sel < 9) begin
                i = {fcodes[sel], 1'($urandom), 5'(8 + $urandom_range(7))};
            end else begin
                i = {lcodes[sel - 9], 8'($urandom)};
            end
            fr_delay = int'($urandom_range(2));
            fw_delay = int'($urandom_range(2));
            wc0 = wr_count;
            predict_push(i);
            send(i);
            wait_done(lat);
            e = sbq.pop_front();
            checks++;
            if ({w_out, c_out, z_out} !== {e.w, e.c, e.z} || lat != e.lat) begin
                errors++;
                $display("[TB] FAIL b2b_%0d ins=%h w/c/z/lat actual=%h/%b/%b/%0d required=%h/%b/%b/%0d",
                         k, i, w_out, c_out, z_out, lat, e.w, e.c, e.z, e.lat);
            end
            checks++;
            if (e.wr ? (wr_count != wc0 + 1 || cap_addr !== e.addr || cap_data !== e.data || !stable_ok)
                     : (wr_count != wc0)) begin
                errors++;
                $display("[TB] FAIL b2b_%0d_wr writes=%0d addr=%h data=%h required wr=%b addr=%h data=%h",
                         k, wr_count - wc0, cap_addr, cap_data, e.wr, e.addr, e.data);
            end
        end
    endtask

    task automatic test_reset_wb();
        exp_t e;
        int lat;
        int n;
        fr_delay = 0; fw_delay = 0;
        predict_push(12'hDFF);
        send(12'hDFF);
        wait_done(lat);
        e = sbq.pop_front();
        checks++;
        if ({w_out, c_out, z_out} !== {e.w, e.c, e.z}) begin
            errors++;
            $display("[TB] FAIL reset_wb_setup w/c/z actual=%h/%b/%b required=%h/%b/%b",
                     w_out, c_out, z_out, e.w, e.c, e.z);
        end
        mem[7] = 8'h0F;
        fw_delay = 10;
        send(12'h1A7);
        n = 0;
        while (!fw_req && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({fw_req, fr_req, w_out, c_out, z_out} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_wb_async fw_req=%b fr_req=%b w/c/z=%h/%b/%b required all 0",
                     fw_req, fr_req, w_out, c_out, z_out);
        end
        bench_reset();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ins_ready !== 1'b1 || fw_req !== 1'b0 || mem[7] !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL reset_wb_release ins_ready=%b fw_req=%b mem7=%h required 1/0/0F",
                     ins_ready, fw_req, mem[7]);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] bad [3];
        exp_t e;
        int lat;
        bad = '{12'h000, 12'hC00, 12'h3C0};
        predict_push(12'hD42);
        send(12'hD42);
        wait_done(lat);
        e = sbq.pop_front();
        checks++;
        if ({w_out, c_out, z_out} !== {e.w, e.c, e.z}) begin
            errors++;
            $display("[TB] FAIL illegal_setup w/c/z actual=%h/%b/%b required=%h/%b/%b",
                     w_out, c_out, z_out, e.w, e.c, e.z);
        end
        for (int k = 0; k < 3; k++) begin
            predict_push(bad[k]);
            send(bad[k]);
            e = sbq.pop_front();
            checks++;
            if (err !== 1'b1 || {w_out, c_out, z_out} !== {e.w, e.c, e.z} || fr_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_%0d err=%b w/c/z=%h/%b/%b fr_req=%b required 1 %h/%b/%b 0",
                         k, err, w_out, c_out, z_out, fr_req, e.w, e.c, e.z);
            end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            checks++;
            if (trap !== 1'b1 || ins_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_%0d_trap trap=%b ins_ready=%b required 1/0", k, trap, ins_ready);
            end
            repeat (3) begin @(posedge clk); #1; end
            checks++;
            if (trap !== 1'b1 || ins_ready !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_%0d_hold trap=%b ins_ready=%b err=%b required 1/0/0",
                         k, trap, ins_ready, err);
            end
            trap_clr = 1'b1;
            @(posedge clk); #1;
            trap_clr = 1'b0;
            checks++;
            if (trap !== 1'b0 || ins_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL illegal_%0d_clr trap=%b ins_ready=%b required 0/1", k, trap, ins_ready);
            end
`else
            checks++;
            if (trap !== 1'b0 || ins_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL illegal_%0d_ready trap=%b ins_ready=%b required 0/1", k, trap, ins_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_%0d_pulse err actual=%b required=0", k, err);
            end
`endif
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 8'h00;
        test_reset();
        test_literal();
        test_subwf();
        test_add_rrf();
        test_swapf();
        test_back_to_back();
        test_reset_wb();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
